mmio_uart_dbg_master: RTL and testbench

Byte-stream debug master that sits directly upstream of the MMIO subsystem and drives its FPro bus port. It consumes command bytes from a UART receive FIFO, performs single 32-bit reads or writes on the FPro bus, and returns results through the UART transmit FIFO. Its purpose is host-side register peek/poke of any slot without processor firmware; it shares the FPro bus via an external mux (out of scope here).

---
 rtl/mmio_uart_dbg_master.sv | 102 ++++++++++
 tb/tb_mmio_uart_dbg_master.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart_dbg_master.sv
// mmio_uart_dbg_master: UART byte-stream command decoder issuing single 32-bit FPro bus reads/writes
module mmio_uart_dbg_master #(
  parameter int TIMEOUT = 1_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_empty,
  output logic        rd_uart,
  output logic [7:0]  tx_data,
  output logic        wr_uart,
  input  logic        tx_full,
  output logic        mmio_cs,
  output logic        mmio_wr,
  output logic        mmio_rd,
  output logic [20:0] mmio_addr,
  output logic [31:0] mmio_wr_data,
  input  logic [31:0] mmio_rd_data,
  output logic        busy,
  output logic        cmd_err
);
  localparam int TW = $clog2(TIMEOUT);
  typedef enum logic [2:0] {IDLE, ADDR, DATA, BUS, RESP} state_t;
  state_t state, state_n;
  logic is_wr, intake, pop, push, tmo_hit, cmd_ok, filler;
  logic [2:0] cnt;
  logic [TW-1:0] tmo;
  logic [20:0] addr_sr;
  logic [23:0] data_sr;
  logic [31:0] resp;
  assign intake = state == IDLE || state == ADDR || state == DATA;
  assign pop = intake && !rx_empty && !reset;
  assign push = state == RESP && !tx_full && !reset;
  assign cmd_ok = rx_data == 8'h57 || rx_data == 8'h52;
  assign filler = rx_data == 8'h0A || rx_data == 8'h0D;
  assign tmo_hit = (state == ADDR || state == DATA) && rx_empty && tmo == TW'(TIMEOUT - 1);
  assign rd_uart = pop;
  assign wr_uart = push;
  assign tx_data = resp[31:24];
  assign mmio_cs = state == BUS && !reset;
  assign mmio_wr = mmio_cs && is_wr;
  assign mmio_rd = mmio_cs && !is_wr;
  assign busy = state != IDLE;
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = (!pop || filler) ? IDLE : cmd_ok ? ADDR : RESP;
      ADDR: state_n = (pop && cnt == 3'd2) ? (is_wr ? DATA : BUS) : tmo_hit ? IDLE : ADDR;
      DATA: state_n = (pop && cnt == 3'd3) ? BUS : tmo_hit ? IDLE : DATA;
      BUS:  state_n = RESP;
      RESP: state_n = (push && cnt == 3'd1) ? IDLE : RESP;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      tmo <= '0;
      is_wr <= 1'b0;
      addr_sr <= '0;
      data_sr <= '0;
      resp <= '0;
      mmio_addr <= '0;
      mmio_wr_data <= '0;
      cmd_err <= 1'b0;
    end else begin
      state <= state_n;
      cmd_err <= (state == IDLE && pop && !filler && !cmd_ok) || tmo_hit;
      tmo <= (pop || !(state == ADDR || state == DATA)) ? '0 : tmo + 1'b1;
      case (state)
        IDLE: if (pop) begin
          is_wr <= rx_data == 8'h57;
          cnt <= cmd_ok ? 3'd0 : 3'd1;
          if (!cmd_ok && !filler) resp <= {8'h3F, 24'h0};
        end
        ADDR: if (pop) begin
          addr_sr <= {addr_sr[12:0], rx_data};
          cnt <= cnt == 3'd2 ? 3'd0 : cnt + 3'd1;
          if (cnt == 3'd2 && !is_wr) mmio_addr <= {addr_sr[12:0], rx_data};
        end
        DATA: if (pop) begin
          data_sr <= {data_sr[15:0], rx_data};
          cnt <= cnt + 3'd1;
          if (cnt == 3'd3) begin
            mmio_addr <= addr_sr;
            mmio_wr_data <= {data_sr, rx_data};
          end
        end
        BUS: begin
          resp <= is_wr ? {8'h4B, 24'h0} : mmio_rd_data;
          cnt <= is_wr ? 3'd1 : 3'd4;
        end
        RESP: if (push) begin
          resp <= {resp[23:0], 8'h0};
          cnt <= cnt - 3'd1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mmio_uart_dbg_master.sv
// tb_mmio_uart_dbg_master: vector table, timing sequences and a randomized byte stream against a command-level model
module tb_mmio_uart_dbg_master;
  logic clk = 0, reset = 1;
  logic [7:0] rx_data = 0, tx_data;
  logic rx_empty = 1, rd_uart, wr_uart, tx_full = 0;
  logic mmio_cs, mmio_wr, mmio_rd, busy, cmd_err;
  logic [20:0] mmio_addr;
  logic [31:0] mmio_wr_data, mmio_rd_data = 0;
  always #5 clk = ~clk;
  mmio_uart_dbg_master #(.TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_empty(rx_empty), .rd_uart(rd_uart),
    .tx_data(tx_data), .wr_uart(wr_uart), .tx_full(tx_full), .mmio_cs(mmio_cs), .mmio_wr(mmio_wr),
    .mmio_rd(mmio_rd), .mmio_addr(mmio_addr), .mmio_wr_data(mmio_wr_data), .mmio_rd_data(mmio_rd_data),
    .busy(busy), .cmd_err(cmd_err)
  );
  typedef struct { logic wr; logic [20:0] addr; logic [31:0] data; } bus_t;
  typedef struct {
    logic [63:0] seq; int n; int nbus; logic bwr; logic [20:0] baddr; logic [31:0] bdata;
    int ntx; logic [31:0] tx; int nerr;
  } vec_t;
  logic [7:0] rx_q[$], stim[$], tx_log[$], exp_tx[$];
  int tx_cyc[$], pop_cyc[$];
  bus_t bus_log[$], exp_bus[$];
  int checks = 0, errors = 0, cyc = 0, errs = 0, exp_errs = 0;
  int err_cyc = -1, bus_cyc = -1, busy_last = -1, tx_viol = 0, strobe_viol = 0;
  bit rnd_mode = 0, hold = 0;

  function automatic logic [31:0] rd_val(input logic [20:0] a);
    return a == 21'h60 ? 32'h12345678 : {a[10:0], a} ^ 32'hC3A5_0F1E;
  endfunction

  function automatic void refresh();
    if (rnd_mode) begin
      hold = $urandom_range(0, 9) < 3;
      tx_full = $urandom_range(0, 9) < 3;
    end else hold = 0;
    rx_empty = hold || rx_q.size() == 0;
    rx_data = rx_q.size() != 0 ? rx_q[0] : 8'h00;
    mmio_rd_data = rd_val(mmio_addr);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    bit popped;
    @(negedge clk);
    popped = rd_uart;
    if (rd_uart) pop_cyc.push_back(cyc);
    if (wr_uart) begin
      tx_log.push_back(tx_data);
      tx_cyc.push_back(cyc);
      if (tx_full) tx_viol++;
    end
    if (mmio_cs) begin
      bus_log.push_back('{mmio_wr, mmio_addr, mmio_wr_data});
      bus_cyc = cyc;
      if (mmio_wr == mmio_rd) strobe_viol++;
    end else if (mmio_wr || mmio_rd) strobe_viol++;
    if (cmd_err) begin
      errs++;
      err_cyc = cyc;
    end
    if (busy) busy_last = cyc;
    @(posedge clk);
    #1;
    if (popped && rx_q.size() != 0) void'(rx_q.pop_front());
    cyc++;
    refresh();
  endtask

  function automatic void push_byte(input logic [7:0] b);
    rx_q.push_back(b);
    stim.push_back(b);
  endfunction

  function automatic void push_bytes(input logic [63:0] v, input int n);
    for (int k = 0; k < n; k++) push_byte(v[63-8*k -: 8]);
    refresh();
  endfunction

  function automatic void clear();
    tx_log.delete(); tx_cyc.delete(); pop_cyc.delete(); bus_log.delete();
    exp_tx.delete(); exp_bus.delete(); stim.delete();
    errs = 0; exp_errs = 0; err_cyc = -1; bus_cyc = -1;
  endfunction

  function automatic void expect_read(input logic [20:0] a);
    logic [31:0] d;
    d = rd_val(a);
    exp_bus.push_back('{1'b0, a, 32'h0});
    for (int k = 0; k < 4; k++) exp_tx.push_back(d[31-8*k -: 8]);
  endfunction

  // Command-level interpretation of the whole byte stream: what the host should see.
  function automatic void model();
    int i;
    logic [7:0] b1;
    i = 0;
    while (i < stim.size()) begin
      b1 = (i + 1 < stim.size()) ? stim[i+1] : 8'h00;
      if (stim[i] == 8'h57 && i + 7 < stim.size()) begin
        exp_bus.push_back('{1'b1, {b1[4:0], stim[i+2], stim[i+3]}, {stim[i+4], stim[i+5], stim[i+6], stim[i+7]}});
        exp_tx.push_back(8'h4B);
        i += 8;
      end else if (stim[i] == 8'h52 && i + 3 < stim.size()) begin
        expect_read({b1[4:0], stim[i+2], stim[i+3]});
        i += 4;
      end else begin
        if (stim[i] != 8'h0A && stim[i] != 8'h0D) begin
          exp_tx.push_back(8'h3F);
          exp_errs++;
        end
        i++;
      end
    end
  endfunction

  task automatic run_idle(input string tag, input int budget);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while ((rx_q.size() != 0 || busy) && n < budget);
    chk({tag, ":done"}, 64'(rx_q.size() == 0 && !busy), 1);
    step();
    step();
  endtask

  task automatic compare(input string tag);
    chk({tag, ":tx_n"}, tx_log.size(), exp_tx.size());
    for (int k = 0; k < tx_log.size() && k < exp_tx.size(); k++)
      chk($sformatf("%s:tx%0d", tag, k), tx_log[k], exp_tx[k]);
    chk({tag, ":bus_n"}, bus_log.size(), exp_bus.size());
    for (int k = 0; k < bus_log.size() && k < exp_bus.size(); k++) begin
      chk($sformatf("%s:bus%0d_wr", tag, k), bus_log[k].wr, exp_bus[k].wr);
      chk($sformatf("%s:bus%0d_addr", tag, k), bus_log[k].addr, exp_bus[k].addr);
      if (exp_bus[k].wr) chk($sformatf("%s:bus%0d_data", tag, k), bus_log[k].data, exp_bus[k].data);
    end
    chk({tag, ":cmd_err_n"}, errs, exp_errs);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ":rd_uart"}, rd_uart, 0);
    chk({tag, ":wr_uart"}, wr_uart, 0);
    chk({tag, ":tx_data"}, tx_data, 0);
    chk({tag, ":mmio_cs"}, mmio_cs, 0);
    chk({tag, ":mmio_wr"}, mmio_wr, 0);
    chk({tag, ":mmio_rd"}, mmio_rd, 0);
    chk({tag, ":mmio_addr"}, mmio_addr, 0);
    chk({tag, ":mmio_wr_data"}, mmio_wr_data, 0);
    chk({tag, ":busy"}, busy, 0);
    chk({tag, ":cmd_err"}, cmd_err, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[7];
    int n, p;
    logic [7:0] b;
    vecs[0] = '{64'h57_00_00_40_00_00_00_A5, 8, 1, 1'b1, 21'h000040, 32'h000000A5, 1, 32'h4B000000, 0};
    vecs[1] = '{64'h52_00_00_60_00_00_00_00, 4, 1, 1'b0, 21'h000060, 32'h0, 4, 32'h12345678, 0};
    vecs[2] = '{64'h0D_0A_52_FF_FF_FF_00_00, 6, 1, 1'b0, 21'h1FFFFF, 32'h0, 4, 32'h3C5AF0E1, 0};
    vecs[3] = '{64'h41_00_00_00_00_00_00_00, 1, 0, 1'b0, 21'h0, 32'h0, 1, 32'h3F000000, 1};
    vecs[4] = '{64'h0A_0D_00_00_00_00_00_00, 2, 0, 1'b0, 21'h0, 32'h0, 0, 32'h0, 0};
    vecs[5] = '{64'h57_E3_12_34_DE_AD_BE_EF, 8, 1, 1'b1, 21'h031234, 32'hDEADBEEF, 1, 32'h4B000000, 0};
    vecs[6] = '{64'h52_A0_00_41_00_00_00_00, 4, 1, 1'b0, 21'h000041, 32'h0, 4, 32'hCB850F5F, 0};

    reset = 1;
    repeat (3) step();
    reset = 0;
    check_zero("reset");

    foreach (vecs[v]) begin
      clear();
      for (int k = 0; k < vecs[v].ntx; k++) exp_tx.push_back(vecs[v].tx[31-8*k -: 8]);
      if (vecs[v].nbus != 0) exp_bus.push_back('{vecs[v].bwr, vecs[v].baddr, vecs[v].bdata});
      exp_errs = vecs[v].nerr;
      push_bytes(vecs[v].seq, vecs[v].n);
      run_idle($sformatf("vec%0d", v), 100);
      compare($sformatf("vec%0d", v));
    end

    // Read latency, back-to-back intake after the last reply byte, unknown-byte reply timing
    clear();
    expect_read(21'h60);
    exp_tx.push_back(8'h3F);
    exp_errs = 1;
    push_bytes(64'h52_00_00_60_41_00_00_00, 5);
    run_idle("timing", 100);
    compare("timing");
    chk("timing:npop", pop_cyc.size(), 5);
    chk("timing:ntx", tx_cyc.size(), 5);
    if (pop_cyc.size() == 5 && tx_cyc.size() == 5) begin
      n = pop_cyc[3];
      chk("timing:pop_run", pop_cyc[3] - pop_cyc[0], 3);
      chk("timing:bus_cyc", bus_cyc, n + 1);
      for (int k = 0; k < 4; k++) chk($sformatf("timing:tx_cyc%0d", k), tx_cyc[k], n + 2 + k);
      chk("timing:b2b_pop", pop_cyc[4], n + 6);
      chk("timing:err_cyc", err_cyc, n + 7);
      chk("timing:3f_cyc", tx_cyc[4], n + 7);
    end

    // Timeout in ADDR after 57 00
    clear();
    push_bytes(64'h57_00_00_00_00_00_00_00, 2);
    for (int k = 0; k < 10 && rx_q.size() != 0; k++) step();
    chk("to:npop", pop_cyc.size(), 2);
    p = pop_cyc.size() != 0 ? pop_cyc[pop_cyc.size()-1] : 0;
    repeat (20) step();
    chk("to:err_n", errs, 1);
    chk("to:err_cyc", err_cyc, p + 17);
    chk("to:busy_last", busy_last, p + 16);
    chk("to:bus_n", bus_log.size(), 0);
    chk("to:tx_n", tx_log.size(), 0);
    clear();
    expect_read(21'h60);
    push_bytes(64'h52_00_00_60_00_00_00_00, 4);
    run_idle("after_to", 100);
    compare("after_to");

    // Backpressure during a read reply
    clear();
    tx_full = 1;
    push_bytes(64'h52_00_00_60_0D_00_00_00, 5);
    for (int k = 0; k < 20 && bus_log.size() == 0; k++) step();
    chk("bp:bus_seen", bus_log.size(), 1);
    repeat (10) step();
    chk("bp:no_tx", tx_log.size(), 0);
    chk("bp:no_pop", pop_cyc.size(), 4);
    chk("bp:rxq", rx_q.size(), 1);
    chk("bp:busy", busy, 1);
    tx_full = 0;
    expect_read(21'h60);
    run_idle("bp", 100);
    compare("bp");

    // Reset in DATA after two data bytes
    clear();
    push_bytes(64'h57_00_00_40_11_22_00_00, 6);
    for (int k = 0; k < 20 && rx_q.size() != 0; k++) step();
    step();
    chk("rd:busy_pre", busy, 1);
    reset = 1;
    step();
    reset = 0;
    check_zero("rst_data");
    repeat (5) step();
    chk("rd:bus_n", bus_log.size(), 0);
    chk("rd:tx_n", tx_log.size(), 0);
    clear();
    exp_bus.push_back('{1'b1, 21'h44, 32'hDEADBEEF});
    exp_tx.push_back(8'h4B);
    push_bytes(64'h57_00_00_44_DE_AD_BE_EF, 8);
    run_idle("post_rst", 100);
    compare("post_rst");

    // Randomized command stream with random RX gaps and TX backpressure
    clear();
    for (int c = 0; c < 40; c++) begin
      case ($urandom_range(0, 5))
        0, 1: begin
          push_byte(8'h57);
          repeat (7) push_byte(8'($urandom));
        end
        2, 3: begin
          push_byte(8'h52);
          repeat (3) push_byte(8'($urandom));
        end
        4: push_byte($urandom_range(0, 1) != 0 ? 8'h0A : 8'h0D);
        default: begin
          do b = 8'($urandom); while (b == 8'h57 || b == 8'h52 || b == 8'h0A || b == 8'h0D);
          push_byte(b);
        end
      endcase
    end
    model();
    rnd_mode = 1;
    refresh();
    run_idle("rnd", 20000);
    rnd_mode = 0;
    tx_full = 0;
    refresh();
    compare("rnd");

    chk("tx_while_full", tx_viol, 0);
    chk("strobe_viol", strobe_viol, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
